// File: rtl/motor_ramp_ctrl.sv
// Four-channel motor duty ramp controller: slew-limited duty, dead-time on reversal,
// immediate brake and emergency stop, with registered duty/drive/settled outputs.
module motor_ramp_ctrl #(
  parameter int unsigned DUTY_MAX   = 2600,
  parameter int unsigned RAMP_DIV   = 100,
  parameter int unsigned STEP       = 8,
  parameter int unsigned DEAD_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        estop,
  output logic [11:0] duty0,
  output logic [11:0] duty1,
  output logic [11:0] duty2,
  output logic [11:0] duty3,
  output logic [7:0]  drive_code,
  output logic [3:0]  at_target
);

  localparam int unsigned NM = 4;
  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [11:0]   DMAX      = 12'(DUTY_MAX);
  localparam logic [11:0]   STEP_W    = 12'(STEP);
  localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_REV   = 2'b01;
  localparam logic [1:0] M_FWD   = 2'b10;
  localparam logic [1:0] M_BRAKE = 2'b11;

  typedef enum logic [1:0] {ST_RUN, ST_DECEL, ST_DEAD} st_t;

  logic [PW-1:0] pre_q;
  logic          tick;
  logic [11:0]   wr_mag;
  logic          unused_wr_bits;

  logic [1:0]    tmode_q [NM];
  logic [1:0]    tmode_d [NM];
  logic [11:0]   tmag_q  [NM];
  logic [11:0]   tmag_d  [NM];
  logic [11:0]   cur_q   [NM];
  logic [11:0]   cur_d   [NM];
  st_t           st_q    [NM];
  st_t           st_d    [NM];
  logic [DW-1:0] dcnt_q  [NM];
  logic [DW-1:0] dcnt_d  [NM];
  logic [NM-1:0] dir_q, dir_d;

  logic [NM-1:0] t_idle, t_brake, t_opp;
  logic [11:0]   t_eff   [NM];

  logic [11:0]   duty_q  [NM];
  logic [11:0]   duty_d  [NM];
  logic [7:0]    code_q, code_d;
  logic [NM-1:0] at_q, at_d;

  assign tick           = (pre_q == PRE_LAST);
  assign wr_mag         = (wr_data[11:0] > DMAX) ? DMAX : wr_data[11:0];
  assign unused_wr_bits = ^wr_data[13:12];

  function automatic logic [11:0] step_lim(input logic [11:0] d);
    return (d > STEP_W) ? STEP_W : d;
  endfunction

  // Target decode relative to each motor's present direction (dir 1 = reverse)
  always_comb begin
    for (int n = 0; n < NM; n++) begin
      t_idle[n]  = (tmode_q[n] == M_IDLE);
      t_brake[n] = (tmode_q[n] == M_BRAKE);
      t_opp[n]   = ((tmode_q[n] == M_FWD) && dir_q[n]) || ((tmode_q[n] == M_REV) && !dir_q[n]);
      t_eff[n]   = t_idle[n] ? 12'd0 : tmag_q[n];
    end
  end

  // State register, including the registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      dir_q  <= '0;
      code_q <= '0;
      at_q   <= '1;
      for (int n = 0; n < NM; n++) begin
        tmode_q[n] <= M_IDLE;
        tmag_q[n]  <= '0;
        cur_q[n]   <= '0;
        st_q[n]    <= ST_RUN;
        dcnt_q[n]  <= '0;
        duty_q[n]  <= '0;
      end
    end else begin
      pre_q  <= tick ? '0 : pre_q + PW'(1);
      dir_q  <= dir_d;
      code_q <= code_d;
      at_q   <= at_d;
      for (int n = 0; n < NM; n++) begin
        tmode_q[n] <= tmode_d[n];
        tmag_q[n]  <= tmag_d[n];
        cur_q[n]   <= cur_d[n];
        st_q[n]    <= st_d[n];
        dcnt_q[n]  <= dcnt_d[n];
        duty_q[n]  <= duty_d[n];
      end
    end
  end

  // Next state: targets, ramp, reversal sequencing; ticks use the pre-write target
  always_comb begin
    dir_d = dir_q;
    for (int n = 0; n < NM; n++) begin
      tmode_d[n] = tmode_q[n];
      tmag_d[n]  = tmag_q[n];
      cur_d[n]   = cur_q[n];
      st_d[n]    = st_q[n];
      dcnt_d[n]  = dcnt_q[n];
      if (estop) begin
        tmode_d[n] = M_IDLE;
        tmag_d[n]  = '0;
        cur_d[n]   = '0;
        st_d[n]    = ST_RUN;
        dcnt_d[n]  = '0;
      end else begin
        if (wr_en && (wr_addr == 2'(n))) begin
          tmode_d[n] = wr_data[15:14];
          tmag_d[n]  = wr_mag;
        end
        if (t_brake[n]) begin
          cur_d[n]  = '0;
          st_d[n]   = ST_RUN;
          dcnt_d[n] = '0;
        end else begin
          case (st_q[n])
            ST_RUN: begin
              if (t_opp[n]) begin
                st_d[n]   = (cur_q[n] == 12'd0) ? ST_DEAD : ST_DECEL;
                dcnt_d[n] = '0;
              end else if (tick) begin
                if (cur_q[n] < t_eff[n]) cur_d[n] = cur_q[n] + step_lim(t_eff[n] - cur_q[n]);
                else                     cur_d[n] = cur_q[n] - step_lim(cur_q[n] - t_eff[n]);
              end
            end
            ST_DECEL: begin
              if (!t_opp[n]) begin
                st_d[n] = ST_RUN;
              end else if (tick) begin
                if (cur_q[n] <= STEP_W) begin
                  cur_d[n]  = '0;
                  st_d[n]   = ST_DEAD;
                  dcnt_d[n] = '0;
                end else begin
                  cur_d[n] = cur_q[n] - STEP_W;
                end
              end
            end
            ST_DEAD: begin
              cur_d[n] = '0;
              if (tick) begin
                if (dcnt_q[n] == DEAD_LAST) begin
                  st_d[n]   = ST_RUN;
                  dcnt_d[n] = '0;
                  if (!t_idle[n]) dir_d[n] = (tmode_q[n] == M_REV);
                end else begin
                  dcnt_d[n] = dcnt_q[n] + DW'(1);
                end
              end
            end
            default: st_d[n] = ST_RUN;
          endcase
        end
      end
    end
  end

  // Output decode; a zero duty never carries a drive code except for brake
  always_comb begin
    code_d = '0;
    at_d   = '0;
    for (int n = 0; n < NM; n++) begin
      duty_d[n] = '0;
      if (estop) begin
        duty_d[n]                 = DMAX;
        code_d[2*(NM-1-n) +: 2]   = M_BRAKE;
      end else if (t_brake[n]) begin
        duty_d[n]                 = tmag_q[n];
        code_d[2*(NM-1-n) +: 2]   = M_BRAKE;
      end else if ((st_q[n] != ST_DEAD) && (cur_q[n] != 12'd0)) begin
        duty_d[n]                 = cur_q[n];
        code_d[2*(NM-1-n) +: 2]   = dir_q[n] ? M_REV : M_FWD;
      end
      at_d[n] = (st_q[n] == ST_RUN) && (t_brake[n] || (cur_q[n] == t_eff[n]))
                && (t_brake[n] || t_idle[n] || !t_opp[n]);
    end
  end

  assign duty0      = duty_q[0];
  assign duty1      = duty_q[1];
  assign duty2      = duty_q[2];
  assign duty3      = duty_q[3];
  assign drive_code = code_q;
  assign at_target  = at_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed ramp/reversal/brake/estop/reset sequences plus
// random traffic, all cross-checked every cycle against a behavioural model.
module tb_motor_ramp_ctrl;

  localparam int DUTY_MAX   = 2600;
  localparam int RAMP_DIV   = 100;
  localparam int STEP       = 8;
  localparam int DEAD_TICKS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        estop;
  logic [11:0] duty0, duty1, duty2, duty3;
  logic [7:0]  drive_code;
  logic [3:0]  at_target;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .DUTY_MAX(DUTY_MAX), .RAMP_DIV(RAMP_DIV), .STEP(STEP), .DEAD_TICKS(DEAD_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .estop(estop), .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
    .drive_code(drive_code), .at_target(at_target)
  );

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // Model: target mode/magnitude, direction (1 = reverse), magnitude, slowing flag,
  // remaining dead ticks; expected outputs are what appears after the next edge.
  int m_tm[4], m_tg[4], m_dir[4], m_cur[4], m_slow[4], m_dead[4];
  int m_pre;
  int e_duty[4];
  logic [7:0] e_code;
  logic [3:0] e_at;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          exp_duty;
    int          exp_code;
    int          exp_at;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [15:0] mk(input int mode, input int mag);
    return {2'(mode), 2'b00, 12'(mag)};
  endfunction

  function automatic int duty_of(input int n);
    case (n)
      0: return int'(duty0);
      1: return int'(duty1);
      2: return int'(duty2);
      default: return int'(duty3);
    endcase
  endfunction

  function automatic int code_of(input int n);
    logic [7:0] c;
    c = drive_code >> (6 - 2*n);
    return int'(c[1:0]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_tm[n] = 0; m_tg[n] = 0; m_dir[n] = 0; m_cur[n] = 0; m_slow[n] = 0; m_dead[n] = 0;
      e_duty[n] = 0;
    end
    m_pre = 0;
    e_code = '0;
    e_at = 4'hF;
  endtask

  task automatic model_step();
    bit tk;
    tk = (m_pre == RAMP_DIV - 1);
    for (int n = 0; n < 4; n++) begin
      bit brk, idl, opp;
      int eff, code;
      brk = (m_tm[n] == 3);
      idl = (m_tm[n] == 0);
      opp = (m_tm[n] == 2 && m_dir[n] == 1) || (m_tm[n] == 1 && m_dir[n] == 0);
      eff = idl ? 0 : m_tg[n];
      if (estop)                               begin e_duty[n] = DUTY_MAX;  code = 3; end
      else if (brk)                            begin e_duty[n] = m_tg[n];   code = 3; end
      else if (m_dead[n] > 0 || m_cur[n] == 0) begin e_duty[n] = 0;         code = 0; end
      else begin e_duty[n] = m_cur[n]; code = (m_dir[n] == 1) ? 1 : 2; end
      e_code[7-2*n -: 2] = 2'(code);
      e_at[n] = (m_slow[n] == 0 && m_dead[n] == 0) && (brk || m_cur[n] == eff) && (brk || idl || !opp);
    end
    m_pre = tk ? 0 : m_pre + 1;
    for (int n = 0; n < 4; n++) begin
      bit brk, idl, opp;
      int eff, diff;
      brk = (m_tm[n] == 3);
      idl = (m_tm[n] == 0);
      opp = (m_tm[n] == 2 && m_dir[n] == 1) || (m_tm[n] == 1 && m_dir[n] == 0);
      eff = idl ? 0 : m_tg[n];
      if (estop) begin
        m_tm[n] = 0; m_tg[n] = 0; m_cur[n] = 0; m_slow[n] = 0; m_dead[n] = 0;
      end else begin
        if (brk) begin
          m_cur[n] = 0; m_slow[n] = 0; m_dead[n] = 0;
        end else if (m_dead[n] > 0) begin
          if (tk) begin
            m_dead[n]--;
            if (m_dead[n] == 0 && !idl) m_dir[n] = (m_tm[n] == 1) ? 1 : 0;
          end
        end else if (m_slow[n] != 0) begin
          if (!opp) m_slow[n] = 0;
          else if (tk) begin
            if (m_cur[n] <= STEP) begin m_cur[n] = 0; m_slow[n] = 0; m_dead[n] = DEAD_TICKS; end
            else m_cur[n] -= STEP;
          end
        end else if (opp) begin
          if (m_cur[n] == 0) m_dead[n] = DEAD_TICKS;
          else m_slow[n] = 1;
        end else if (tk) begin
          diff = eff - m_cur[n];
          if (diff > STEP) m_cur[n] += STEP;
          else if (diff < -STEP) m_cur[n] -= STEP;
          else m_cur[n] = eff;
        end
        if (wr_en && int'(wr_addr) == n) begin
          m_tm[n] = int'(wr_data[15:14]);
          m_tg[n] = (int'(wr_data[11:0]) > DUTY_MAX) ? DUTY_MAX : int'(wr_data[11:0]);
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    edge_cnt++;
    wr_en = 1'b0;
    checks++;
    if (int'(duty0) != e_duty[0] || int'(duty1) != e_duty[1] || int'(duty2) != e_duty[2] ||
        int'(duty3) != e_duty[3] || drive_code !== e_code || at_target !== e_at) begin
      errors++;
      $display("FAIL model edge %0d: duty=%0d/%0d/%0d/%0d code=%h at=%b, expected duty=%0d/%0d/%0d/%0d code=%h at=%b",
               edge_cnt, duty0, duty1, duty2, duty3, drive_code, at_target,
               e_duty[0], e_duty[1], e_duty[2], e_duty[3], e_code, e_at);
    end
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    cycle();
  endtask

  task automatic run_to(input int e);
    while (edge_cnt < e) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    estop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_duty0", int'(duty0), 0);
    chk("reset_code", int'(drive_code), 0);
    chk("reset_at", int'(at_target), 15);
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    int hold;
    bit seq_ok;
    vecs[0] = '{3, mk(3, 4095), 2600, 3, 1};
    vecs[1] = '{0, mk(3, 2601), 2600, 3, 1};
    vecs[2] = '{1, mk(3, 2600), 2600, 3, 1};
    vecs[3] = '{2, mk(3, 0),    0,    3, 1};
    vecs[4] = '{3, mk(3, 1234), 1234, 3, 1};
    vecs[5] = '{0, mk(0, 0),    0,    0, 1};
    vecs[6] = '{2, 16'h3FFF,    0,    0, 1};

    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; estop = 1'b0;
    #2;

    // Forward ramp 0 -> 100 in steps of 8, one step per 100 clocks
    do_reset();
    wr(0, mk(2, 100));
    for (int k = 1; k <= 13; k++) begin
      run_to(100*k + 1);
      chk($sformatf("ramp_duty0_t%0d", k), int'(duty0), (8*k > 100) ? 100 : 8*k);
      if (k == 1 || k == 13) chk("ramp_code0", code_of(0), 2);
      if (k == 12 || k == 13) chk($sformatf("ramp_at0_t%0d", k), int'(at_target[0]), (k == 13) ? 1 : 0);
    end

    // Reversal: decelerate, dead time, then ramp in reverse
    do_reset();
    wr(1, mk(2, 40));
    run_to(549);
    wr(1, mk(1, 40));
    for (int k = 0; k < 5; k++) begin
      run_to(601 + 100*k);
      chk($sformatf("decel_duty1_%0d", k), int'(duty1), 32 - 8*k);
      chk($sformatf("decel_code1_%0d", k), code_of(1), (k < 4) ? 2 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      run_to(1001 + 100*k);
      chk($sformatf("dead_code1_%0d", k), code_of(1), 0);
    end
    run_to(1201);
    chk("dead_at1", int'(at_target[1]), 0);
    run_to(1501);
    chk("rev_duty1_first", int'(duty1), 8);
    chk("rev_code1_first", code_of(1), 1);
    run_to(1901);
    chk("rev_duty1_final", int'(duty1), 40);
    chk("rev_at1_final", int'(at_target[1]), 1);

    // Reversal abandoned mid-deceleration: back to RUN without dead time
    do_reset();
    wr(2, mk(2, 40));
    run_to(549);
    wr(2, mk(1, 40));
    run_to(701);
    chk("abort_duty2_dec", int'(duty2), 24);
    run_to(749);
    wr(2, mk(2, 40));
    seq_ok = 1'b1;
    while (edge_cnt < 901) begin
      cycle();
      if (code_of(2) != 2) seq_ok = 1'b0;
    end
    chk("abort_code2_never_coast", int'(seq_ok), 1);
    chk("abort_duty2_final", int'(duty2), 40);
    chk("abort_at2", int'(at_target[2]), 1);

    // Brake / clamp / idle table
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      cycle();
      chk($sformatf("vec%0d_duty", i), duty_of(vecs[i].addr), vecs[i].exp_duty);
      chk($sformatf("vec%0d_code", i), code_of(vecs[i].addr), vecs[i].exp_code);
      chk($sformatf("vec%0d_at", i), int'(at_target[vecs[i].addr]), vecs[i].exp_at);
    end

    // Emergency stop mid-ramp, with a write attempted while it is held
    do_reset();
    wr(0, mk(2, 100));
    run_to(450);
    chk("estop_pre_duty0", int'(duty0), 32);
    estop = 1'b1;
    cycle();
    chk("estop_code", int'(drive_code), 255);
    chk("estop_duty0", int'(duty0), 2600);
    wr(1, mk(2, 50));
    repeat (10) cycle();
    chk("estop_duty1_held", int'(duty1), 2600);
    chk("estop_duty3_held", int'(duty3), 2600);
    estop = 1'b0;
    repeat (2) cycle();
    chk("post_estop_code", int'(drive_code), 0);
    chk("post_estop_duty0", int'(duty0), 0);
    run_to(700);
    chk("post_estop_duty1", int'(duty1), 0);
    chk("post_estop_at", int'(at_target), 15);

    // Asynchronous reset while a motor sits in dead time
    do_reset();
    wr(0, mk(2, 100));
    wr(1, mk(1, 8));
    run_to(350);
    chk("pre_rst_duty0", int'(duty0), 24);
    chk("pre_rst_at1_dead", int'(at_target[1]), 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_duty0", int'(duty0), 0);
    chk("async_rst_code", int'(drive_code), 0);
    chk("async_rst_at", int'(at_target), 15);

    // Random traffic against the model
    do_reset();
    hold = 0;
    for (int i = 0; i < 8000; i++) begin
      if (estop) begin
        if (hold == 0) estop = 1'b0;
        else hold--;
      end else if ($urandom_range(0, 999) == 0) begin
        estop = 1'b1;
        hold = $urandom_range(1, 40);
      end
      if ($urandom_range(0, 59) == 0) begin
        wr_en = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   12'(($urandom_range(0, 3) == 0) ? $urandom_range(2590, 4095) : $urandom_range(0, 120))};
      end
      cycle();
    end
    estop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL provide parameter DUTY_MAX, default 2600, the full-scale duty count of the downstream PWM period.
REQ-002 SHALL provide parameter RAMP_DIV, default 100, the clk cycles per ramp tick.
REQ-003 SHALL provide parameter STEP, default 8, the maximum duty change per tick.
REQ-004 SHALL provide parameter DEAD_TICKS, default 4, the number of ramp ticks of coast (code 00) held between directions.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 SHALL have ports wr_en (in, 1), wr_addr (in, 2, motor index) and wr_data (in, 16: [15:14] mode, [11:0] magnitude), a single-cycle target write.
REQ-008 SHALL have port estop, input, 1 bit, a level-sensitive emergency stop.
REQ-009 SHALL have ports duty0, duty1, duty2 and duty3, output, 12 bits each, the registered duty per motor.
REQ-010 SHALL have port drive_code, output, 8 bits, registered; motor n drives bits [7-2n:6-2n] as {A,B}.
REQ-011 SHALL have port at_target, output, 4 bits, registered; bit n is high when motor n has settled.

Function
REQ-012 SHALL use mode encoding 10 forward, 01 reverse, 11 brake, 00 idle, for both wr_data[15:14] and drive_code.
REQ-013 SHALL on wr_en latch the target mode and magnitude for motor wr_addr, with magnitude clamped to DUTY_MAX; no ack; last write wins.
REQ-014 SHALL apply a write on the edge it is sampled; a tick on that same edge uses the previous target.
REQ-015 SHALL run a free-running prescaler counting 0..RAMP_DIV-1 and assert an internal tick for one cycle at RAMP_DIV-1, then wrap to 0.
REQ-016 SHALL keep per motor a current direction (fwd/rev), a current magnitude cur (12 bits) and a state in {RUN, DECEL, DEAD}.
REQ-017 SHALL in RUN, when the target direction equals the current direction or the target is idle, move cur toward the target magnitude on each tick by min(STEP, |diff|); an idle target counts as magnitude 0; no overshoot, no wrap below 0.
REQ-018 SHALL in RUN, when the target direction is opposite and cur>0, go to DECEL; if cur==0, go directly to DEAD.
REQ-019 SHALL in DECEL decrement cur by min(STEP, cur) per tick; at cur==0 go to DEAD; if the target returns to the current direction first, go back to RUN.
REQ-020 SHALL in DEAD output code 00 and duty 0 for DEAD_TICKS ticks, then load the latest target direction and go to RUN.
REQ-021 SHALL for a brake target, from any state, immediately output code 11 and duty = target magnitude, set cur=0 and state RUN; no ramping applies.
REQ-022 SHALL for a non-brake target output duty = cur, and code = current direction when cur>0, else 00; duty 0 is never paired with a drive code.
REQ-023 SHALL compute at_target[n] = (state RUN) and (cur equals the target magnitude, or brake) and (direction matches, or the target is idle/brake).
REQ-024 SHALL, while estop is high, force all motors to code 11 with duty DUTY_MAX, cur=0, state RUN, clear all targets to idle/0 and ignore wr_en.
REQ-025 SHALL, after estop falls, leave all motors idle until they are rewritten.
REQ-026 SHALL update all outputs one clk after the internal state change (registered).

Reset
REQ-027 SHALL while rst_n=0 asynchronously clear the prescaler, all targets (idle/0), cur, direction (fwd) and state (RUN), set duty0-3=0 and drive_code=8'h00, and set at_target=4'b1111.
REQ-028 SHALL start the prescaler from 0 on the first clk after rst_n deasserts, and abandon any ramp or DEAD in progress at reset.

Verification
REQ-029 SHALL test: write motor0 fwd 100 with defaults -> duty0 rises 8 per 100 clks: 8, 16, ..., 96, 100; code 10; at_target[0] high after tick 13.
REQ-030 SHALL test: motor1 at fwd 40, write rev 40 -> duty decrements 32, 24, ..., 0; then 4 ticks of code 00; then code 01 ramping to 40.
REQ-031 SHALL test: motor2 in DECEL, rewrite to fwd -> returns to RUN and ramps up without entering DEAD.
REQ-032 SHALL test: write mode 11, magnitude 4095 to motor3 -> next cycle drive_code[1:0]=11 and duty3=2600 (clamped).
REQ-033 SHALL test: estop pulse mid-ramp -> all codes 11 and duties 2600 while high; after it falls, all outputs 0/00; a wr_en during estop is ignored.
REQ-034 SHALL test: rst_n asserted during DEAD -> outputs 0 immediately, with no clk edge needed.
